// File: rtl/pre_if_stage_pkg.sv
// Shared widths, reset PC, state encoding and PC helpers for the pre-IF stage.
package pre_if_stage_pkg;

  localparam int BR_BUS_WD        = 33;
  localparam int PFS_TO_FS_BUS_WD = 34;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HALT = 2'd2
  } pfs_state_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic word_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pre_if_stage_if.sv
// SRAM-like instruction fetch bus (request/address-accept half).
interface pre_if_stage_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;

  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok);
endinterface

// File: rtl/pre_if_stage_redirect_sel.sv
// Priority mux for fetch redirects: exception > ertn > branch.
module pfs_redirect_sel
  import pre_if_stage_pkg::*;
(
  input  logic [BR_BUS_WD-1:0] br_bus,
  input  logic                 ertn_flush,
  input  logic [31:0]          csr_era,
  input  logic                 wb_ex,
  input  logic [31:0]          ex_entry,
  output logic                 redir,
  output logic [31:0]          redir_target
);

  // Select the highest-priority redirect target
  always_comb begin
    redir = wb_ex | ertn_flush | br_bus[BR_BUS_WD-1];
    if (wb_ex) begin
      redir_target = ex_entry;
    end else if (ertn_flush) begin
      redir_target = csr_era;
    end else if (br_bus[BR_BUS_WD-1]) begin
      redir_target = br_bus[31:0];
    end else begin
      redir_target = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues fetch requests and hands accepted
// addresses to IF through a one-entry buffer, tagging wrong-path fetches.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fs_allowin,
  input  logic [BR_BUS_WD-1:0]        br_bus,
  input  logic                        ertn_flush,
  input  logic [31:0]                 csr_era,
  input  logic                        wb_ex,
  input  logic [31:0]                 ex_entry,
  pre_if_stage_if.master              inst_sram,
  output logic                        pfs_to_fs_valid,
  output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus
);

  logic        redir_s;
  logic [31:0] redir_target_s;
  logic        ob_free_s;
  logic        launch_s;
  logic        aligned_s;
  logic [31:0] fetch_addr_s;
  logic        req_s;
  logic [31:0] addr_s;

  pfs_state_e  state_r;
  logic [31:0] npc_r;
  logic [31:0] req_pc_r;
  logic        cancel_pend_r;
  logic        ob_valid_r;
  logic        ob_cancel_r;
  logic        ob_adef_r;
  logic [31:0] ob_pc_r;

  pfs_redirect_sel u_redirect_sel (
    .br_bus       (br_bus),
    .ertn_flush   (ertn_flush),
    .csr_era      (csr_era),
    .wb_ex        (wb_ex),
    .ex_entry     (ex_entry),
    .redir        (redir_s),
    .redir_target (redir_target_s)
  );

  // Launching only into a free slot keeps the buffer empty at every handshake
  assign ob_free_s    = ~ob_valid_r | fs_allowin;
  assign launch_s     = ob_free_s & ~reset;
  assign fetch_addr_s = redir_s ? redir_target_s : npc_r;
  assign aligned_s    = word_aligned(fetch_addr_s);

  // Request/address drive; a pending request is held until accepted
  always_comb begin
    req_s  = 1'b0;
    addr_s = req_pc_r;
    case (state_r)
      S_IDLE: begin
        req_s  = launch_s & aligned_s;
        addr_s = fetch_addr_s;
      end
      S_REQ: begin
        req_s  = ~reset;
        addr_s = req_pc_r;
      end
      S_HALT: begin
        req_s  = 1'b0;
        addr_s = npc_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = req_pc_r;
      end
    endcase
  end

  assign inst_sram.req   = req_s;
  assign inst_sram.addr  = addr_s;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'b0000;
  assign inst_sram.wdata = 32'h0000_0000;

  assign pfs_to_fs_valid = ob_valid_r & ~reset;
  assign pfs_to_fs_bus   = {ob_cancel_r | redir_s, ob_adef_r, ob_pc_r};

  // Fetch FSM, next-PC tracking and output buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      npc_r         <= RESET_PC;
      req_pc_r      <= RESET_PC;
      cancel_pend_r <= 1'b0;
      ob_valid_r    <= 1'b0;
      ob_cancel_r   <= 1'b0;
      ob_adef_r     <= 1'b0;
      ob_pc_r       <= 32'h0000_0000;
    end else begin
      if (ob_valid_r && fs_allowin) begin
        ob_valid_r <= 1'b0;
      end else if (ob_valid_r && redir_s) begin
        ob_cancel_r <= 1'b1;
      end else begin
        ob_valid_r <= ob_valid_r;
      end

      case (state_r)
        S_IDLE: begin
          // A redirect that cannot launch now is remembered for the next try
          if (redir_s) begin
            npc_r <= redir_target_s;
          end
          if (launch_s) begin
            if (aligned_s) begin
              if (inst_sram.addr_ok) begin
                ob_valid_r  <= 1'b1;
                ob_cancel_r <= 1'b0;
                ob_adef_r   <= 1'b0;
                ob_pc_r     <= fetch_addr_s;
                npc_r       <= next_pc(fetch_addr_s);
              end else begin
                req_pc_r <= fetch_addr_s;
                state_r  <= S_REQ;
              end
            end else begin
              ob_valid_r  <= 1'b1;
              ob_cancel_r <= 1'b0;
              ob_adef_r   <= 1'b1;
              ob_pc_r     <= fetch_addr_s;
              state_r     <= S_HALT;
            end
          end
        end
        S_REQ: begin
          if (redir_s) begin
            npc_r         <= redir_target_s;
            cancel_pend_r <= 1'b1;
          end
          if (inst_sram.addr_ok) begin
            ob_valid_r    <= 1'b1;
            ob_cancel_r   <= cancel_pend_r | redir_s;
            ob_adef_r     <= 1'b0;
            ob_pc_r       <= req_pc_r;
            cancel_pend_r <= 1'b0;
            state_r       <= S_IDLE;
            if (!(cancel_pend_r || redir_s)) begin
              npc_r <= next_pc(req_pc_r);
            end
          end
        end
        S_HALT: begin
          if (redir_s) begin
            npc_r   <= redir_target_s;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
Pre-IF stage of the 5-stage LoongArch pipeline. It owns the fetch PC and issues instruction requests on the SRAM-like bus (req/addr_ok). It hands accepted fetch addresses to the IF stage through a one-entry output buffer, and IF then collects the data_ok responses. It absorbs redirects (exception, ertn, branch) that arrive while a request is waiting for addr_ok, and tags wrong-path fetches with a cancel bit instead of dropping the request.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fs_allowin  in  1  IF stage can accept an entry this cycle
br_bus  in  BR_BUS_WD(33)  {br_taken, br_target[31:0]} from ID
ertn_flush  in  1  ertn committed in WB
csr_era  in  32  ertn return address
wb_ex  in  1  exception committed in WB
ex_entry  in  32  exception entry address
inst_sram_req  out  1  fetch request
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10
inst_sram_wstrb  out  4  constant 0
inst_sram_addr  out  32  fetch address
inst_sram_wdata  out  32  constant 0
inst_sram_addr_ok  in  1  request accepted
pfs_to_fs_valid  out  1  output buffer valid
pfs_to_fs_bus  out  PFS_TO_FS_BUS_WD(34)  {cancel, adef, pc[31:0]}

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. Reset sets state=S_IDLE, npc=RESET_PC, cancel_pend=0, ob_valid=0, ob_cancel=0, ob_adef=0. During reset, inst_sram_req=0 and pfs_to_fs_valid=0.
- Redirect: redir = wb_ex | ertn_flush | br_taken. Target priority is wb_ex > ertn_flush > br_taken.
- Fetch address: fetch_addr = redir ? redir_target : npc.
- Slot check: ob_free = !ob_valid | fs_allowin. This guarantees the buffer is empty whenever a handshake completes.
- State S_IDLE:
  - launch = ob_free & !reset.
  - If fetch_addr[1:0]==0: req = launch, addr = fetch_addr.
    - If addr_ok arrives in the same cycle: load the buffer with {0, 0, fetch_addr}, set npc <= fetch_addr+4, stay in S_IDLE.
    - If not: latch req_pc <= fetch_addr, go to S_REQ.
  - If fetch_addr is misaligned and launch=1: no bus request. Load the buffer with {0, 1, fetch_addr} and go to S_HALT.
- State S_REQ:
  - req=1 and addr=req_pc, held stable until addr_ok. Never withdrawn, including under redirect.
  - A redirect here sets npc <= redir_target and cancel_pend <= 1. A later redirect overwrites npc.
  - On addr_ok: load the buffer with {cancel_pend|redir, 0, req_pc}. If neither cancel_pend nor redir is set, npc <= req_pc+4; otherwise keep the redirected npc. Clear cancel_pend and go to S_IDLE.
- State S_HALT: req=0. A redirect sets npc <= redir_target and goes to S_IDLE; the first fetch follows next cycle.
- Output buffer:
  - Transfers to IF when ob_valid & fs_allowin.
  - A redirect while ob_valid and not transferring sets ob_cancel <= 1.
  - The output cancel bit is ob_cancel | redir, so an entry transferring in the redirect cycle arrives already cancelled.
  - IF must still consume data_ok for cancelled entries and discard the instruction.
- Latency:
  - Redirect in S_IDLE: the request goes out the same cycle.
  - Redirect in S_REQ: the request goes out in the cycle after addr_ok.
  - Back-to-back with addr_ok always high and IF never stalling: one fetch per cycle.
- Arithmetic: npc increments are mod 2^32; 0xfffffffc+4 wraps to 0.
- At most one request is outstanding between req and addr_ok.

Decomposition:
- mycpu.h additions: PFS_TO_FS_BUS_WD=34, RESET_PC default, state encodings S_IDLE/S_REQ/S_HALT.
- Sub-module: pfs_redirect_sel, a combinational priority mux producing {redir, redir_target}. Everything else stays in one module.

Test Plan:
- Release reset, addr_ok tied 1, fs_allowin 1 -> req addrs 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles, all cancel=0.
- addr_ok held low 3 cycles at 0x1c000010 -> req and addr stable for 4 cycles; buffer loads pc 0x1c000010 on the 4th; next req 0x1c000014.
- br_taken to 0x1c000100 in cycle 2 of a pending 0x1c000010 request -> that entry emitted with cancel=1; next req 0x1c000100.
- wb_ex (ex_entry 0x1c008000) and br_taken (0x1c000200) in the same S_IDLE cycle -> req addr 0x1c008000 that cycle, no cancel.
- br_taken to 0x1c000102 -> buffer entry {0, adef=1, 0x1c000102}, no req, S_HALT; wb_ex to 0x1c008000 -> fetch resumes at 0x1c008000.
- ob_valid with fs_allowin=0, then ertn_flush (era 0x1c000040) -> held entry gets cancel=1; the entry transferring in a redirect cycle shows cancel=1 on the bus; the next fetch is 0x1c000040.
